// File: rtl/screen_pkg.sv
// Shared types and constants for the title screen sequencer and its helpers.
package screen_pkg;

  localparam int COORD_W = 11;
  localparam int RGB_W   = 8;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [RGB_W-1:0]   rgb_t;

  // Colour driven when no item claims the pixel.
  localparam rgb_t TRANSPARENT = 8'h00;

  // Sequencer phases: waiting for a request, revealing items one at a time,
  // and steady display with blinking items.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REVEAL = 2'd1,
    SHOW   = 2'd2
  } state_t;

endpackage

// File: rtl/screen_item_rect.sv
// Registered hit-test for one screen item: tells whether the current scan
// position lies inside the item rectangle and where inside it.
module screen_item_rect
  import screen_pkg::*;
#(
  parameter coord_t RECT_X = 11'd0,
  parameter coord_t RECT_Y = 11'd0,
  parameter coord_t RECT_W = 11'd1,
  parameter coord_t RECT_H = 11'd1
) (
  input  logic   clk,
  input  logic   reset,
  input  coord_t pixelX,
  input  coord_t pixelY,
  output logic   insideRect,
  output coord_t offsetX,
  output coord_t offsetY
);

  // Far edges carry one extra bit so a rectangle touching the top of the
  // coordinate range cannot wrap around and alias to a small value.
  logic [COORD_W:0] xEnd;
  logic [COORD_W:0] yEnd;
  logic             hit;

  logic   insideRect_q;
  coord_t offsetX_q;
  coord_t offsetY_q;

  assign xEnd = {1'b0, RECT_X} + {1'b0, RECT_W};
  assign yEnd = {1'b0, RECT_Y} + {1'b0, RECT_H};
  assign hit  = (pixelX >= RECT_X) && ({1'b0, pixelX} < xEnd) &&
                (pixelY >= RECT_Y) && ({1'b0, pixelY} < yEnd);

  // Register the hit flag and the in-rectangle offset, zeroing the offset
  // outside so downstream bitmap lookups see a stable address.
  always_ff @(posedge clk) begin
    if (reset) begin
      insideRect_q <= 1'b0;
      offsetX_q    <= '0;
      offsetY_q    <= '0;
    end else begin
      insideRect_q <= hit;
      offsetX_q    <= hit ? coord_t'(pixelX - RECT_X) : '0;
      offsetY_q    <= hit ? coord_t'(pixelY - RECT_Y) : '0;
    end
  end

  assign insideRect = insideRect_q;
  assign offsetX    = offsetX_q;
  assign offsetY    = offsetY_q;

endmodule

// File: rtl/title_screen_seq.sv
// Title screen sequencer: reveals items one after another on frame
// boundaries, then blinks selected items, and composites the item bitmaps.
module title_screen_seq
  import screen_pkg::*;
#(
  parameter int                     NUM_ITEMS     = 3,
  parameter logic [NUM_ITEMS*11-1:0] ITEM_X       = {11'd448, 11'd192, 11'd70},
  parameter logic [NUM_ITEMS*11-1:0] ITEM_Y       = {11'd230, 11'd80, 11'd230},
  parameter logic [NUM_ITEMS*11-1:0] ITEM_W       = {11'd128, 11'd256, 11'd128},
  parameter logic [NUM_ITEMS*11-1:0] ITEM_H       = {3{11'd128}},
  parameter int                     REVEAL_FRAMES = 30,
  parameter int                     BLINK_FRAMES  = 32,
  parameter logic [NUM_ITEMS-1:0]   BLINK_MASK    = 3'b001
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    startOfFrame,
  input  logic                    show,
  input  coord_t                  pixelX,
  input  coord_t                  pixelY,
  input  logic [NUM_ITEMS-1:0]    itemDR,
  input  logic [8*NUM_ITEMS-1:0]  itemRGB,
  output logic [11*NUM_ITEMS-1:0] offsetX,
  output logic [11*NUM_ITEMS-1:0] offsetY,
  output logic [NUM_ITEMS-1:0]    insideRect,
  output logic                    screenDR,
  output rgb_t                    screenRGB,
  output logic                    revealDone
);

  localparam int MAX_FRAMES = (REVEAL_FRAMES > BLINK_FRAMES) ? REVEAL_FRAMES : BLINK_FRAMES;
  localparam int CNT_W      = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;

  localparam logic [CNT_W-1:0] REVEAL_LAST = CNT_W'(REVEAL_FRAMES - 1);
  localparam logic [CNT_W-1:0] BLINK_LAST  = CNT_W'(BLINK_FRAMES - 1);
  localparam logic [3:0]       ITEMS_ALL   = 4'(NUM_ITEMS);

  state_t           state_q, state_d;
  logic [3:0]       revealCount_q, revealCount_d;
  logic [CNT_W-1:0] frameCnt_q, frameCnt_d;
  logic             blinkPhase_q, blinkPhase_d;

  logic [NUM_ITEMS-1:0] itemEn;
  logic                 screenDR_q, screenDR_d;
  rgb_t                 screenRGB_q, screenRGB_d;

  genvar g;
  generate
    for (g = 0; g < NUM_ITEMS; g++) begin : gen_rect
      screen_item_rect #(
        .RECT_X(ITEM_X[g*11 +: 11]),
        .RECT_Y(ITEM_Y[g*11 +: 11]),
        .RECT_W(ITEM_W[g*11 +: 11]),
        .RECT_H(ITEM_H[g*11 +: 11])
      ) u_rect (
        .clk       (clk),
        .reset     (reset),
        .pixelX    (pixelX),
        .pixelY    (pixelY),
        .insideRect(insideRect[g]),
        .offsetX   (offsetX[g*11 +: 11]),
        .offsetY   (offsetY[g*11 +: 11])
      );
    end
  endgenerate

  // Sequencer state and counters; blink phase idles in the visible half.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      revealCount_q <= '0;
      frameCnt_q    <= '0;
      blinkPhase_q  <= 1'b1;
    end else begin
      state_q       <= state_d;
      revealCount_q <= revealCount_d;
      frameCnt_q    <= frameCnt_d;
      blinkPhase_q  <= blinkPhase_d;
    end
  end

  // Next-state logic: dropping show aborts immediately, everything else
  // only advances on frame boundaries so enables never change mid-frame.
  always_comb begin
    state_d       = state_q;
    revealCount_d = revealCount_q;
    frameCnt_d    = frameCnt_q;
    blinkPhase_d  = blinkPhase_q;
    if (!show) begin
      state_d       = IDLE;
      revealCount_d = '0;
      frameCnt_d    = '0;
      blinkPhase_d  = 1'b1;
    end else if (startOfFrame) begin
      case (state_q)
        IDLE: begin
          revealCount_d = 4'd1;
          frameCnt_d    = '0;
          blinkPhase_d  = 1'b1;
          state_d       = (ITEMS_ALL == 4'd1) ? SHOW : REVEAL;
        end
        REVEAL: begin
          if (frameCnt_q == REVEAL_LAST) begin
            frameCnt_d    = '0;
            revealCount_d = revealCount_q + 4'd1;
            if (revealCount_q + 4'd1 == ITEMS_ALL) begin
              state_d      = SHOW;
              blinkPhase_d = 1'b1;
            end
          end else begin
            frameCnt_d = frameCnt_q + CNT_W'(1);
          end
        end
        SHOW: begin
          if (frameCnt_q == BLINK_LAST) begin
            frameCnt_d   = '0;
            blinkPhase_d = ~blinkPhase_q;
          end else begin
            frameCnt_d = frameCnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Item enables; gating with show makes the composite go dark on the same
  // edge the sequencer falls back to idle.
  always_comb begin
    itemEn = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      itemEn[i] = show && (4'(i) < revealCount_q) &&
                  !((state_q == SHOW) && BLINK_MASK[i] && !blinkPhase_q);
    end
  end

  // Priority composite: scanning from the top index down lets the lowest
  // enabled, drawing item overwrite the others.
  always_comb begin
    screenDR_d  = 1'b0;
    screenRGB_d = TRANSPARENT;
    for (int i = NUM_ITEMS - 1; i >= 0; i--) begin
      if (itemEn[i] && itemDR[i]) begin
        screenDR_d  = 1'b1;
        screenRGB_d = itemRGB[i*8 +: 8];
      end
    end
  end

  // Registered composite output.
  always_ff @(posedge clk) begin
    if (reset) begin
      screenDR_q  <= 1'b0;
      screenRGB_q <= TRANSPARENT;
    end else begin
      screenDR_q  <= screenDR_d;
      screenRGB_q <= screenRGB_d;
    end
  end

  assign screenDR   = screenDR_q;
  assign screenRGB  = screenRGB_q;
  assign revealDone = (state_q == SHOW);

endmodule

// File: tb/tb_title_screen_seq.sv
// Directed bench for title_screen_seq: hit-test corners, staged reveal,
// blinking, priority, show abort and reset, with a queue of expected
// composite results.
module tb_title_screen_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        startOfFrame;
  logic        show;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic [2:0]  itemDR;
  logic [23:0] itemRGB;
  logic [32:0] offsetX;
  logic [32:0] offsetY;
  logic [2:0]  insideRect;
  logic        screenDR;
  logic [7:0]  screenRGB;
  logic        revealDone;

  typedef struct {
    string      tag;
    logic       expDR;
    logic [7:0] expRGB;
    logic       expDone;
  } expect_t;

  expect_t scoreboard[$];
  int testsRun    = 0;
  int testsFailed = 0;

  localparam logic [7:0] RGB0 = 8'h03;
  localparam logic [7:0] RGB1 = 8'hE0;
  localparam logic [7:0] RGB2 = 8'h1C;

  always #5 clk = ~clk;

  title_screen_seq #(
    .NUM_ITEMS    (3),
    .REVEAL_FRAMES(2),
    .BLINK_FRAMES (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .startOfFrame(startOfFrame),
    .show        (show),
    .pixelX      (pixelX),
    .pixelY      (pixelY),
    .itemDR      (itemDR),
    .itemRGB     (itemRGB),
    .offsetX     (offsetX),
    .offsetY     (offsetY),
    .insideRect  (insideRect),
    .screenDR    (screenDR),
    .screenRGB   (screenRGB),
    .revealDone  (revealDone)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
      else begin
        testsFailed++;
        $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
  endtask

  task automatic checkOutput();
    expect_t e;
    if (scoreboard.size() == 0) begin
      testsRun++;
      testsFailed++;
      $error("[TB] FAIL scoreboard_underflow: observed empty expected entry");
    end else begin
      e = scoreboard.pop_front();
      checkValue({e.tag, "_dr"},   32'(screenDR),   32'(e.expDR));
      checkValue({e.tag, "_rgb"},  32'(screenRGB),  32'(e.expRGB));
      checkValue({e.tag, "_done"}, 32'(revealDone), 32'(e.expDone));
    end
  endtask

  task automatic applyStimulus(input string tag, input logic [2:0] dr,
                               input logic eDR, input logic [7:0] eRGB, input logic eDone);
    expect_t e;
    itemDR    = dr;
    e.tag     = tag;
    e.expDR   = eDR;
    e.expRGB  = eRGB;
    e.expDone = eDone;
    scoreboard.push_back(e);
    step();
    checkOutput();
  endtask

  task automatic frame();
    startOfFrame = 1'b1;
    step();
    startOfFrame = 1'b0;
  endtask

  task automatic probePixel(input string tag, input logic [10:0] x, input logic [10:0] y,
                            input logic [2:0] eIn, input int item,
                            input logic [10:0] eOffX, input logic [10:0] eOffY);
    pixelX = x;
    pixelY = y;
    step();
    checkValue({tag, "_in"},   32'(insideRect), 32'(eIn));
    checkValue({tag, "_offx"}, 32'(offsetX[item*11 +: 11]), 32'(eOffX));
    checkValue({tag, "_offy"}, 32'(offsetY[item*11 +: 11]), 32'(eOffY));
  endtask

  initial begin
    reset        = 1'b1;
    startOfFrame = 1'b1;
    show         = 1'b1;
    pixelX       = 11'd70;
    pixelY       = 11'd230;
    itemDR       = 3'b111;
    itemRGB      = {RGB2, RGB1, RGB0};
    repeat (3) step();
    checkValue("rst_in",   32'(insideRect), 32'd0);
    checkValue("rst_offx", 32'(offsetX),    32'd0);
    checkValue("rst_dr",   32'(screenDR),   32'd0);
    checkValue("rst_rgb",  32'(screenRGB),  32'd0);
    checkValue("rst_done", 32'(revealDone), 32'd0);

    reset        = 1'b0;
    startOfFrame = 1'b0;
    show         = 1'b0;
    step();

    probePixel("px_item0_corner", 11'd70,  11'd230, 3'b001, 0, 11'd0,   11'd0);
    probePixel("px_item0_right",  11'd198, 11'd230, 3'b000, 0, 11'd0,   11'd0);
    probePixel("px_item0_last",   11'd197, 11'd357, 3'b001, 0, 11'd127, 11'd127);
    probePixel("px_item0_left",   11'd69,  11'd230, 3'b000, 0, 11'd0,   11'd0);
    probePixel("px_item1_mid",    11'd200, 11'd100, 3'b010, 1, 11'd8,   11'd20);
    probePixel("px_item2_last",   11'd575, 11'd357, 3'b100, 2, 11'd127, 11'd127);
    probePixel("px_item2_below",  11'd575, 11'd358, 3'b000, 2, 11'd0,   11'd0);

    show = 1'b1;
    applyStimulus("idle_no_frame", 3'b111, 1'b0, 8'h00, 1'b0);

    frame();
    applyStimulus("f1_item0",      3'b111, 1'b1, RGB0,  1'b0);
    applyStimulus("f1_no_item1",   3'b110, 1'b0, 8'h00, 1'b0);
    frame();
    applyStimulus("f2_no_item1",   3'b010, 1'b0, 8'h00, 1'b0);
    frame();
    applyStimulus("f3_item1",      3'b010, 1'b1, RGB1,  1'b0);
    applyStimulus("f3_no_item2",   3'b100, 1'b0, 8'h00, 1'b0);
    frame();
    applyStimulus("f4_no_item2",   3'b100, 1'b0, 8'h00, 1'b0);
    frame();
    applyStimulus("f5_item2",      3'b100, 1'b1, RGB2,  1'b1);
    applyStimulus("f5_overlap",    3'b110, 1'b1, RGB1,  1'b1);
    applyStimulus("f5_item0_vis",  3'b111, 1'b1, RGB0,  1'b1);
    frame();
    applyStimulus("f6_item0_vis",  3'b111, 1'b1, RGB0,  1'b1);
    frame();
    applyStimulus("f7_item0_hid",  3'b111, 1'b1, RGB1,  1'b1);
    applyStimulus("f7_only0_hid",  3'b001, 1'b0, 8'h00, 1'b1);
    applyStimulus("f7_item2_stdy", 3'b100, 1'b1, RGB2,  1'b1);
    frame();
    applyStimulus("f8_item0_hid",  3'b001, 1'b0, 8'h00, 1'b1);
    frame();
    applyStimulus("f9_item0_vis",  3'b001, 1'b1, RGB0,  1'b1);

    pixelX       = 11'd70;
    pixelY       = 11'd230;
    itemDR       = 3'b111;
    startOfFrame = 1'b1;
    reset        = 1'b1;
    step();
    checkValue("show_rst_dr",   32'(screenDR),   32'd0);
    checkValue("show_rst_rgb",  32'(screenRGB),  32'd0);
    checkValue("show_rst_done", 32'(revealDone), 32'd0);
    checkValue("show_rst_in",   32'(insideRect), 32'd0);
    reset        = 1'b0;
    startOfFrame = 1'b0;

    applyStimulus("post_rst_idle", 3'b111, 1'b0, 8'h00, 1'b0);
    frame();
    applyStimulus("r2_f1_item0",   3'b111, 1'b1, RGB0,  1'b0);
    frame();
    frame();
    applyStimulus("r2_f3_item1",   3'b010, 1'b1, RGB1,  1'b0);

    show = 1'b0;
    applyStimulus("abort_dark",    3'b111, 1'b0, 8'h00, 1'b0);
    show = 1'b1;
    applyStimulus("rearm_idle",    3'b111, 1'b0, 8'h00, 1'b0);
    frame();
    applyStimulus("restart_item0", 3'b111, 1'b1, RGB0,  1'b0);
    applyStimulus("restart_no1",   3'b010, 1'b0, 8'h00, 1'b0);

    if (scoreboard.size() != 0) begin
      testsRun++;
      testsFailed++;
      $error("[TB] FAIL scoreboard_leftover: observed %0d entries expected 0", scoreboard.size());
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/title_screen_seq.md
TITLE_SCREEN_SEQ -- requirements
Module: title_screen_seq

Interface
REQ-001 Parameter NUM_ITEMS, default 3: number of screen items (1..8).
REQ-002 Parameter ITEM_X / ITEM_Y, default {11'd448,11'd192,11'd70} / {11'd230,11'd80,11'd230}: packed NUM_ITEMS x 11-bit top-left corners, item 0 in the LSBs.
REQ-003 Parameter ITEM_W / ITEM_H, default {11'd128,11'd256,11'd128} / {3{11'd128}}: packed NUM_ITEMS x 11-bit sizes.
REQ-004 Parameter REVEAL_FRAMES, default 30: frames between successive item reveals (>=1).
REQ-005 Parameter BLINK_FRAMES, default 32: frames per blink half-period (>=1).
REQ-006 Parameter BLINK_MASK, default 3'b001: items that blink once fully revealed.
REQ-007 clk  in  1  system clock.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 startOfFrame  in  1  one-cycle pulse per video frame.
REQ-010 show  in  1  level; title screen requested.
REQ-011 pixelX, pixelY  in  11 each  current scan position.
REQ-012 itemDR  in  NUM_ITEMS  per-item bitmap drawing request.
REQ-013 itemRGB  in  8*NUM_ITEMS  per-item bitmap colour, item 0 in the LSBs.
REQ-014 offsetX, offsetY  out  11*NUM_ITEMS  pixel offset inside each item rectangle.
REQ-015 insideRect  out  NUM_ITEMS  pixel lies inside item rectangle.
REQ-016 screenDR  out  1  composite drawing request.
REQ-017 screenRGB  out  8  composite colour.
REQ-018 revealDone  out  1  all items revealed.

Function
REQ-019 insideRect[i] SHALL be registered, 1 cycle after pixelX/Y, high iff ITEM_X[i] <= pixelX < ITEM_X[i]+ITEM_W[i] and same for Y; sums SHALL be computed 12-bit (no wrap).
REQ-020 offsetX[i]/offsetY[i] SHALL be registered alongside insideRect[i], equal to pixel minus corner when inside, 0 otherwise.
REQ-021 FSM states IDLE, REVEAL, SHOW; reset state IDLE.
REQ-022 IDLE: revealCount=0, frameCnt=0; on startOfFrame with show=1 -> REVEAL, revealCount=1.
REQ-023 REVEAL: frameCnt increments on each startOfFrame; at frameCnt==REVEAL_FRAMES-1 it clears and revealCount increments; when revealCount reaches NUM_ITEMS -> SHOW, blinkPhase=1 (visible), frameCnt=0.
REQ-024 SHOW: frameCnt counts startOfFrame; at BLINK_FRAMES-1 it clears and blinkPhase toggles.
REQ-025 show=0 in any state SHALL force IDLE on the next clock edge, clearing all counters; show reasserted restarts reveal from item 0.
REQ-026 Item i SHALL be enabled iff i < revealCount and not (state==SHOW and BLINK_MASK[i] and blinkPhase==0).
REQ-027 screenDR/screenRGB SHALL be registered, 1 cycle after itemDR/itemRGB: lowest-index enabled item with itemDR set wins; none -> screenDR=0, screenRGB=8'h00.
REQ-028 revealDone SHALL be high exactly while state==SHOW.
REQ-029 State/counter updates SHALL occur only on cycles with startOfFrame=1 (except REQ-025), so enable changes never tear mid-frame.
REQ-030 NUM_ITEMS==1 SHALL enter SHOW on the first startOfFrame with show=1.

Reset
REQ-031 reset=1 at a clock edge SHALL set state IDLE, all counters 0, blinkPhase 1, insideRect/offsetX/offsetY/screenDR/screenRGB/revealDone 0, overriding all other inputs including mid-reveal.

Structure
REQ-032 Package screen_pkg SHALL hold coordinate type (11-bit), RGB type (8-bit), TRANSPARENT=8'h00 and the FSM state enum.
REQ-033 One sub-module screen_item_rect (registered hit-test + offset for one item) SHALL be instantiated NUM_ITEMS times via generate.

Verification
REQ-034 Pixel (70,230) -> next cycle insideRect[0]=1, offsetX[0]=0, offsetY[0]=0; pixel (198,230) -> insideRect[0]=0.
REQ-035 show=1, REVEAL_FRAMES=2: screenDR follows item 0 after 1st startOfFrame, item 1 from 3rd, item 2 from 5th with revealDone=1.
REQ-036 SHOW, BLINK_FRAMES=2, itemDR[0]=1 held: item 0 visible 2 frames, hidden 2 frames, repeating; items 1,2 steady.
REQ-037 Overlapping itemDR=3'b110, RGB1=8'hE0, RGB2=8'h1C, all revealed -> screenRGB=8'hE0.
REQ-038 show dropped mid-REVEAL -> next cycle screenDR=0, state IDLE; reassert -> reveal restarts at item 0.
REQ-039 reset pulsed in SHOW -> all outputs 0 next cycle, revealDone=0.
